// File: rtl/mem_stage_pkg.sv
// Shared mycpu constants, bus layouts and MEM-stage state codes.
package mem_stage_pkg;

   localparam int unsigned ES_TO_MS_BUS_WD = 74;
   localparam int unsigned MS_TO_WS_BUS_WD = 70;
   localparam int unsigned HAZARD_BUS_WD   = 7;

   localparam logic [2:0] LD_W  = 3'd0;
   localparam logic [2:0] LD_B  = 3'd1;
   localparam logic [2:0] LD_BU = 3'd2;
   localparam logic [2:0] LD_H  = 3'd3;
   localparam logic [2:0] LD_HU = 3'd4;

   typedef enum logic [1:0] {
      MS_EMPTY = 2'd0,
      MS_WAIT  = 2'd1,
      MS_READY = 2'd2
   } ms_state_e;

   typedef struct packed {
      logic [2:0]  ld_type;
      logic        res_from_mem;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] alu_result;
      logic [31:0] pc;
   } es_to_ms_t;

   typedef struct packed {
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] final_result;
      logic [31:0] pc;
   } ms_to_ws_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Selects and extends the byte/halfword addressed by a load from the returned word.
module mem_stage_load_align
   import mem_stage_pkg::*;
(
   input  logic [2:0]  ld_type,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] word,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word[7:0];
      case (addr_lo)
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase
      // addr_lo[0] is ignored for halfwords; misalignment is not trapped here
      half_sel = addr_lo[1] ? word[31:16] : word[15:0];

      result = word;
      case (ld_type)
         LD_B:    result = {{24{byte_sel[7]}}, byte_sel};
         LD_BU:   result = {24'd0, byte_sel};
         LD_H:    result = {{16{half_sel[15]}}, half_sel};
         LD_HU:   result = {16'd0, half_sel};
         default: result = word;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// mycpu memory-access stage: latches EXE result, waits for load data, aligns it
// and hands the finished instruction to WB, with hazard/forward info for ID.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic                       clk,
   input  logic                       resetn,
   output logic                       ms_allowin,
   input  logic                       es_to_ms_valid,
   input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
   input  logic                       ws_allowin,
   output logic                       ms_to_ws_valid,
   output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
   input  logic                       data_sram_data_ok,
   input  logic [31:0]                data_sram_rdata,
   output logic [HAZARD_BUS_WD-1:0]   ms_hazard_bus,
   output logic                       ms_ld_pending,
   output logic [31:0]                ms_forward
);

   ms_state_e   state, state_nxt, entry_state;
   es_to_ms_t   es_bus, bus_r;
   ms_to_ws_t   ws_bus;
   logic [31:0] rdata_r;
   logic [31:0] load_src, aligned, final_result;
   logic        ms_valid, ms_ready_go, accept, capture;

   assign es_bus = es_to_ms_t'(es_to_ms_bus);

   // Handshake and next-state logic
   always_comb begin
      ms_valid    = (state != MS_EMPTY);
      ms_ready_go = (state == MS_READY) || ((state == MS_WAIT) && data_sram_data_ok);
      ms_allowin  = !ms_valid || (ms_ready_go && ws_allowin);
      accept      = es_to_ms_valid && ms_allowin;
      entry_state = es_bus.res_from_mem ? MS_WAIT : MS_READY;
      capture     = (state == MS_WAIT) && data_sram_data_ok && !ws_allowin;
      state_nxt   = state;
      case (state)
         MS_EMPTY: begin
            if (accept) state_nxt = entry_state;
         end
         MS_WAIT: begin
            if (data_sram_data_ok) begin
               if (ws_allowin) state_nxt = accept ? entry_state : MS_EMPTY;
               else            state_nxt = MS_READY;
            end
         end
         MS_READY: begin
            if (ws_allowin) state_nxt = accept ? entry_state : MS_EMPTY;
         end
         default: state_nxt = MS_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= MS_EMPTY;
      else         state <= state_nxt;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)     bus_r <= '0;
      else if (accept) bus_r <= es_bus;
   end

   // Holds load data only when WB stalls in the data_ok cycle
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)      rdata_r <= 32'd0;
      else if (capture) rdata_r <= data_sram_rdata;
   end

   assign load_src = (state == MS_READY) ? rdata_r : data_sram_rdata;

   mem_stage_load_align u_load_align (
      .ld_type (bus_r.ld_type),
      .addr_lo (bus_r.alu_result[1:0]),
      .word    (load_src),
      .result  (aligned)
   );

   assign final_result = bus_r.res_from_mem ? aligned : bus_r.alu_result;

   always_comb begin
      ws_bus.gr_we        = bus_r.gr_we;
      ws_bus.dest         = bus_r.dest;
      ws_bus.final_result = final_result;
      ws_bus.pc           = bus_r.pc;
   end

   assign ms_to_ws_valid = ms_valid && ms_ready_go;
   assign ms_to_ws_bus   = ws_bus;
   assign ms_hazard_bus  = {ms_valid, bus_r.gr_we, bus_r.dest};
   assign ms_ld_pending  = (state == MS_WAIT) && !data_sram_data_ok;
   assign ms_forward     = final_result;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus random traffic against a slot-level model.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        resetn;
   logic        ms_allowin;
   logic        es_to_ms_valid;
   logic [73:0] es_to_ms_bus;
   logic        ws_allowin;
   logic        ms_to_ws_valid;
   logic [69:0] ms_to_ws_bus;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;
   logic [6:0]  ms_hazard_bus;
   logic        ms_ld_pending;
   logic [31:0] ms_forward;

   int total = 0;
   int bad   = 0;

   // Model: at most one instruction resident, plus whether its load data has arrived
   logic        m_full = 1'b0;
   logic [73:0] m_insn = '0;
   logic        m_have = 1'b0;
   logic [31:0] m_data = '0;

   mem_stage dut (
      .clk               (clk),
      .resetn            (resetn),
      .ms_allowin        (ms_allowin),
      .es_to_ms_valid    (es_to_ms_valid),
      .es_to_ms_bus      (es_to_ms_bus),
      .ws_allowin        (ws_allowin),
      .ms_to_ws_valid    (ms_to_ws_valid),
      .ms_to_ws_bus      (ms_to_ws_bus),
      .data_sram_data_ok (data_sram_data_ok),
      .data_sram_rdata   (data_sram_rdata),
      .ms_hazard_bus     (ms_hazard_bus),
      .ms_ld_pending     (ms_ld_pending),
      .ms_forward        (ms_forward)
   );

   always #5 clk = ~clk;

   function automatic logic [73:0] mk(input logic [2:0] ld, input logic rfm, input logic we,
                                      input logic [4:0] dest, input logic [31:0] alu,
                                      input logic [31:0] pc);
      return {ld, rfm, we, dest, alu, pc};
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] t, input logic [1:0] a,
                                            input logic [31:0] w);
      logic [31:0] sb;
      logic [31:0] sh;
      sb = w >> (32'(a) * 32'd8);
      sh = w >> (a[1] ? 32'd16 : 32'd0);
      case (t)
         3'd1:    return {{24{sb[7]}}, sb[7:0]};
         3'd2:    return {24'd0, sb[7:0]};
         3'd3:    return {{16{sh[15]}}, sh[15:0]};
         3'd4:    return {16'd0, sh[15:0]};
         default: return w;
      endcase
   endfunction

   task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
      end
   endtask

   function automatic logic m_ready();
      return m_full && (!m_insn[70] || m_have || data_sram_data_ok);
   endfunction

   function automatic logic [31:0] m_result();
      logic [31:0] src;
      src = m_have ? m_data : data_sram_rdata;
      return m_insn[70] ? ref_load(m_insn[73:71], m_insn[33:32], src) : m_insn[63:32];
   endfunction

   // Compare every DUT output against the model for the current cycle
   task automatic compare();
      logic rdy;
      rdy = m_ready();
      chk("ws_valid", 70'(ms_to_ws_valid), 70'(rdy));
      chk("allowin", 70'(ms_allowin), 70'(!m_full || (rdy && ws_allowin)));
      chk("ld_pending", 70'(ms_ld_pending),
          70'(m_full && m_insn[70] && !m_have && !data_sram_data_ok));
      chk("haz_valid", 70'(ms_hazard_bus[6]), 70'(m_full));
      if (m_full) chk("haz_bus", 70'(ms_hazard_bus), 70'({1'b1, m_insn[69], m_insn[68:64]}));
      if (rdy) begin
         chk("ws_bus", ms_to_ws_bus, {m_insn[69], m_insn[68:64], m_result(), m_insn[31:0]});
         chk("forward", 70'(ms_forward), 70'(m_result()));
      end
   endtask

   task automatic drive(input logic v, input logic [73:0] b, input logic wa,
                        input logic dok, input logic [31:0] rd);
      @(negedge clk);
      es_to_ms_valid    = v;
      es_to_ms_bus      = b;
      ws_allowin        = wa;
      data_sram_data_ok = dok;
      data_sram_rdata   = rd;
      #1;
      compare();
   endtask

   task automatic tick();
      logic rdy, allow;
      @(posedge clk);
      if (!resetn) begin
         m_full = 1'b0;
      end else begin
         rdy   = m_ready();
         allow = !m_full || (rdy && ws_allowin);
         if (rdy && ws_allowin) begin
            m_full = 1'b0;
         end else if (m_full && m_insn[70] && !m_have && data_sram_data_ok) begin
            m_have = 1'b1;
            m_data = data_sram_rdata;
         end
         if (allow && es_to_ms_valid) begin
            m_full = 1'b1;
            m_insn = es_to_ms_bus;
            m_have = 1'b0;
         end
      end
   endtask

   task automatic idle(input logic wa);
      drive(1'b0, '0, wa, 1'b0, 32'hDEAD_BEEF);
   endtask

   initial begin
      logic        v, wa, dok;
      logic [73:0] b;

      resetn = 1'b0;
      es_to_ms_valid = 1'b0; es_to_ms_bus = '0; ws_allowin = 1'b1;
      data_sram_data_ok = 1'b0; data_sram_rdata = '0;
      #12;
      chk("rst_ws_valid", 70'(ms_to_ws_valid), 70'd0);
      chk("rst_pending", 70'(ms_ld_pending), 70'd0);
      chk("rst_hazard", 70'(ms_hazard_bus), 70'd0);
      chk("rst_allowin", 70'(ms_allowin), 70'd1);
      @(negedge clk); resetn = 1'b1;

      // ALU op passes through in one cycle
      drive(1'b1, mk(3'd0, 1'b0, 1'b1, 5'd3, 32'h1234_5678, 32'h1C00_0000), 1'b1, 1'b0, '0); tick();
      idle(1'b1);
      chk("t1_valid", 70'(ms_to_ws_valid), 70'd1);
      chk("t1_result", 70'(ms_to_ws_bus[63:32]), 70'(32'h1234_5678));
      chk("t1_pending", 70'(ms_ld_pending), 70'd0);
      tick();

      // LB from byte 3, data three cycles late
      drive(1'b1, mk(3'd1, 1'b1, 1'b1, 5'd4, 32'h0000_1003, 32'h1C00_0004), 1'b1, 1'b0, '0); tick();
      for (int i = 0; i < 3; i++) begin
         idle(1'b1);
         chk("t2_pending", 70'(ms_ld_pending), 70'd1);
         tick();
      end
      drive(1'b0, '0, 1'b1, 1'b1, 32'h80FF_FF7F);
      chk("t2_valid", 70'(ms_to_ws_valid), 70'd1);
      chk("t2_result", 70'(ms_to_ws_bus[63:32]), 70'(32'hFFFF_FF80));
      tick();

      // LHU, upper half, WB stalled on the data_ok cycle
      drive(1'b1, mk(3'd4, 1'b1, 1'b1, 5'd5, 32'h0000_2002, 32'h1C00_0008), 1'b1, 1'b0, '0); tick();
      drive(1'b0, '0, 1'b0, 1'b1, 32'h8001_0002);
      chk("t3_allowin0", 70'(ms_allowin), 70'd0);
      tick();
      drive(1'b1, mk(3'd0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h1C00_000C), 1'b0, 1'b0, 32'hDEAD_BEEF);
      chk("t3_allowin1", 70'(ms_allowin), 70'd0);
      tick();
      drive(1'b0, '0, 1'b1, 1'b0, 32'hDEAD_BEEF);
      chk("t3_result", 70'(ms_to_ws_bus[63:32]), 70'(32'h0000_8001));
      tick();

      // Stream ALU, LW, ALU with immediate data_ok
      drive(1'b1, mk(3'd0, 1'b0, 1'b1, 5'd6, 32'h0000_0011, 32'h1C00_0100), 1'b1, 1'b0, '0); tick();
      drive(1'b1, mk(3'd0, 1'b1, 1'b1, 5'd7, 32'h0000_0040, 32'h1C00_0104), 1'b1, 1'b0, '0);
      chk("t4_alu_pc", 70'(ms_to_ws_bus[31:0]), 70'(32'h1C00_0100));
      tick();
      drive(1'b1, mk(3'd0, 1'b0, 1'b1, 5'd8, 32'h0000_0022, 32'h1C00_0108), 1'b1, 1'b1, 32'hCAFE_0001);
      chk("t4_lw_pc", 70'(ms_to_ws_bus[31:0]), 70'(32'h1C00_0104));
      chk("t4_allowin", 70'(ms_allowin), 70'd1);
      tick();
      idle(1'b1);
      chk("t4_alu2_pc", 70'(ms_to_ws_bus[31:0]), 70'(32'h1C00_0108));
      tick();

      // Reset while waiting for load data, then a stray data_ok
      drive(1'b1, mk(3'd0, 1'b1, 1'b1, 5'd9, 32'h0000_0080, 32'h1C00_0200), 1'b1, 1'b0, '0); tick();
      idle(1'b1);
      #2; resetn = 1'b0; #1;
      chk("t5_rst_valid", 70'(ms_to_ws_valid), 70'd0);
      chk("t5_rst_hazard", 70'(ms_hazard_bus), 70'd0);
      tick();
      @(negedge clk); resetn = 1'b1;
      drive(1'b0, '0, 1'b1, 1'b1, 32'h1111_2222);
      chk("t5_late_valid", 70'(ms_to_ws_valid), 70'd0);
      chk("t5_late_hazard", 70'(ms_hazard_bus), 70'd0);
      tick();
      idle(1'b1);
      chk("t5_after", 70'(ms_to_ws_valid), 70'd0);
      tick();

      // LH vs LW of the same word
      drive(1'b1, mk(3'd3, 1'b1, 1'b1, 5'd10, 32'h0000_3000, 32'h1C00_0300), 1'b1, 1'b0, '0); tick();
      drive(1'b0, '0, 1'b1, 1'b1, 32'h0000_8000);
      chk("t6_lh", 70'(ms_forward), 70'(32'hFFFF_8000));
      tick();
      drive(1'b1, mk(3'd0, 1'b1, 1'b1, 5'd11, 32'h0000_3000, 32'h1C00_0304), 1'b1, 1'b0, '0); tick();
      drive(1'b0, '0, 1'b1, 1'b1, 32'h0000_8000);
      chk("t6_lw", 70'(ms_forward), 70'(32'h0000_8000));
      tick();

      // Random traffic; data_ok only while a load is waiting
      for (int n = 0; n < 3000; n++) begin
         v   = ($urandom % 4) != 0;
         wa  = ($urandom % 4) != 0;
         b   = mk(3'($urandom % 8), 1'($urandom % 2), 1'($urandom % 2), 5'($urandom),
                  32'($urandom), 32'($urandom));
         dok = (m_full && m_insn[70] && !m_have) ? (($urandom % 3) == 0) : 1'b0;
         drive(v, b, wa, dok, 32'($urandom));
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
